mux8_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 8:1 single-bit mux channel between 8 requesters.
- Requester k presents a request `req[k]` and a data bit `din[k]`.
- The block picks the owner, drives the mux select, holds ownership for a bounded tenure, and registers the selected bit onto the shared output with a valid flag.
- Sits in front of the 8:1 mux datapath and replaces its free-running select stimulus.

---
 rtl/mux8_rr_sched.sv | 123 ++++++++++++
 tb/tb_mux8_rr_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux channel among 8 requesters.
// The owner holds the channel for at most HOLD cycles. The selected bit is registered
// onto out_o/valid_o, one cycle behind grant_o.
module mux8_rr_sched #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] req_i,
  input  logic [7:0] din_i,
  output logic [7:0] grant_o,
  output logic [2:0] sel_o,
  output logic       out_o,
  output logic       valid_o,
  output logic       busy_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [7:0]         grant_q, grant_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               release_w;
  logic [2:0]         win_w;

  // First requester after base, wrapping; base itself is checked last.
  function automatic logic [2:0] pick(input logic [2:0] base, input logic [7:0] r);
    logic [2:0] w;
    logic [2:0] idx;
    logic       found;
    w     = base;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = base + 3'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Next-state logic for arbitration, tenure counting and ownership.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    release_w = !req_i[sel_q] || (cnt_q == '0);
    win_w     = pick((state_q == StIdle) ? ptr_q : sel_q, req_i);
    unique case (state_q)
      StIdle: begin
        if (req_i != 8'h00) begin
          state_d = StGrant;
          grant_d = 8'h01 << win_w;
          sel_d   = win_w;
          ptr_d   = win_w;
          cnt_d   = CNT_W'(HOLD - 1);
        end
      end
      StGrant: begin
        if (!release_w) begin
          cnt_d = cnt_q - 1'b1;
        end else if (req_i != 8'h00) begin
          // Hand over in the same edge, no idle bubble.
          grant_d = 8'h01 << win_w;
          sel_d   = win_w;
          ptr_d   = win_w;
          cnt_d   = CNT_W'(HOLD - 1);
        end else begin
          state_d = StIdle;
          grant_d = 8'h00;
          ptr_d   = sel_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered output path: sample the owner's bit while granted, else hold out.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    if (state_q == StGrant) begin
      out_d   = din_i[sel_q];
      valid_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd7;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign grant_o = grant_q;
  assign sel_o   = sel_q;
  assign out_o   = out_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == StGrant);

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched; three instances (HOLD=4, 2, 1) share stimulus.
module tb_mux8_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;

  logic [7:0] grant4, grant2, grant1;
  logic [2:0] sel4, sel2, sel1;
  logic       out4, out2, out1;
  logic       valid4, valid2, valid1;
  logic       busy4, busy2, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux8_rr_sched #(.HOLD(4), .CNT_W(8)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .din_i(din),
    .grant_o(grant4), .sel_o(sel4), .out_o(out4), .valid_o(valid4), .busy_o(busy4)
  );
  mux8_rr_sched #(.HOLD(2), .CNT_W(8)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .din_i(din),
    .grant_o(grant2), .sel_o(sel2), .out_o(out2), .valid_o(valid2), .busy_o(busy2)
  );
  mux8_rr_sched #(.HOLD(1), .CNT_W(8)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .din_i(din),
    .grant_o(grant1), .sel_o(sel1), .out_o(out1), .valid_o(valid1), .busy_o(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    din   = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      step();
      if (grant4 !== 8'h00) begin
        errors++; $display("FAIL reset_grant c%0d: got %h want 00", i, grant4);
      end
      checks++;
      if (valid4 !== 1'b0) begin
        errors++; $display("FAIL reset_valid c%0d: got %b want 0", i, valid4);
      end
      checks++;
      if (busy4 !== 1'b0) begin
        errors++; $display("FAIL reset_busy c%0d: got %b want 0", i, busy4);
      end
      checks++;
      if (out4 !== 1'b0) begin
        errors++; $display("FAIL reset_out c%0d: got %b want 0", i, out4);
      end
      checks++;
      if (sel4 !== 3'd0) begin
        errors++; $display("FAIL reset_sel c%0d: got %0d want 0", i, sel4);
      end
      checks++;
    end
  endtask

  task automatic test_hold_single();
    apply_reset();
    req = 8'b0000_0001;
    din = 8'b0000_0001;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (grant4 !== 8'h01) begin
        errors++; $display("FAIL single_grant c%0d: got %h want 01", i, grant4);
      end
      checks++;
      if (sel4 !== 3'd0 || busy4 !== 1'b1) begin
        errors++; $display("FAIL single_sel_busy c%0d: got %0d/%b want 0/1", i, sel4, busy4);
      end
      checks++;
      if (valid4 !== (i >= 2)) begin
        errors++; $display("FAIL single_valid c%0d: got %b want %b", i, valid4, (i >= 2));
      end
      checks++;
      if (i >= 2 && out4 !== 1'b1) begin
        errors++; $display("FAIL single_out c%0d: got %b want 1", i, out4);
      end
      if (i >= 2) checks++;
    end
  endtask

  task automatic test_rr_all();
    int unsigned sel_exp[17] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 0};
    logic        out_exp[17] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [2:0]  s1;
    apply_reset();
    req = 8'hFF;
    din = 8'b1100_1001;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (sel2 !== 3'(sel_exp[k-1])) begin
        errors++; $display("FAIL rr2_sel e%0d: got %0d want %0d", k, sel2, sel_exp[k-1]);
      end
      checks++;
      if (grant2 !== (8'h01 << sel_exp[k-1])) begin
        errors++; $display("FAIL rr2_grant e%0d: got %h want %h", k, grant2,
                           8'h01 << sel_exp[k-1]);
      end
      checks++;
      if (k >= 2 && (out2 !== out_exp[k-1] || valid2 !== 1'b1)) begin
        errors++; $display("FAIL rr2_out e%0d: got %b/%b want %b/1", k, out2, valid2,
                           out_exp[k-1]);
      end
      if (k >= 2) checks++;
      s1 = 3'(k - 1);
      if (sel1 !== s1) begin
        errors++; $display("FAIL rr1_sel e%0d: got %0d want %0d", k, sel1, s1);
      end
      checks++;
    end
  endtask

  task automatic test_drop_switch();
    apply_reset();
    req = 8'b1000_0100;
    din = 8'b1000_0000;
    step();
    if (grant4 !== 8'h04 || sel4 !== 3'd2 || valid4 !== 1'b0) begin
      errors++; $display("FAIL drop_first: got %h/%0d/%b want 04/2/0", grant4, sel4, valid4);
    end
    checks++;
    req = 8'b1000_0000;
    step();
    if (grant4 !== 8'h80 || sel4 !== 3'd7 || busy4 !== 1'b1) begin
      errors++; $display("FAIL drop_switch: got %h/%0d/%b want 80/7/1", grant4, sel4, busy4);
    end
    checks++;
    if (valid4 !== 1'b1 || out4 !== 1'b0) begin
      errors++; $display("FAIL drop_switch_out: got %b/%b want 1/0", valid4, out4);
    end
    checks++;
    req = 8'h00;
    step();
    if (grant4 !== 8'h00 || sel4 !== 3'd7 || busy4 !== 1'b0) begin
      errors++; $display("FAIL drop_idle: got %h/%0d/%b want 00/7/0", grant4, sel4, busy4);
    end
    checks++;
    if (valid4 !== 1'b1 || out4 !== 1'b1) begin
      errors++; $display("FAIL drop_idle_out: got %b/%b want 1/1", valid4, out4);
    end
    checks++;
    step();
    if (valid4 !== 1'b0 || out4 !== 1'b1 || grant4 !== 8'h00) begin
      errors++; $display("FAIL drop_valid_fall: got %b/%b/%h want 0/1/00", valid4, out4,
                         grant4);
    end
    checks++;
  endtask

  task automatic test_wrap();
    int unsigned sel_exp[9] = '{0, 0, 0, 0, 7, 7, 7, 7, 0};
    logic [2:0]  s1;
    req = 8'b1000_0001;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (sel4 !== 3'(sel_exp[k-1]) || grant4 !== (8'h01 << sel_exp[k-1])) begin
        errors++; $display("FAIL wrap4 e%0d: got %0d/%h want %0d", k, sel4, grant4,
                           sel_exp[k-1]);
      end
      checks++;
      s1 = (k % 2 == 1) ? 3'd0 : 3'd7;
      if (sel1 !== s1) begin
        errors++; $display("FAIL wrap1 e%0d: got %0d want %0d", k, sel1, s1);
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    if (grant4 !== 8'h00 || valid4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL async_rst: got %h/%b/%b want 00/0/0", grant4, valid4, busy4);
    end
    checks++;
    if (sel4 !== 3'd0 || out4 !== 1'b0 || grant1 !== 8'h00) begin
      errors++; $display("FAIL async_rst_sel: got %0d/%b/%h want 0/0/00", sel4, out4, grant1);
    end
    checks++;
    req = 8'h10;
    din = 8'h10;
    step();
    rst_n = 1'b1;
    step();
    if (grant4 !== 8'h10 || sel4 !== 3'd4 || busy4 !== 1'b1 || valid4 !== 1'b0) begin
      errors++; $display("FAIL post_rst_grant: got %h/%0d/%b/%b want 10/4/1/0", grant4, sel4,
                         busy4, valid4);
    end
    checks++;
    step();
    if (valid4 !== 1'b1 || out4 !== 1'b1 || grant4 !== 8'h10) begin
      errors++; $display("FAIL post_rst_out: got %b/%b/%h want 1/1/10", valid4, out4, grant4);
    end
    checks++;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    din   = 8'h00;
    test_reset();
    test_hold_single();
    test_rr_all();
    test_drop_switch();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
